// File: rtl/demorgan_sweep.sv
// demorgan_sweep
// Exhaustive De Morgan checker for WIDTH inputs. A start pulse walks a
// counter through every input vector, one per cycle. Each vector is evaluated
// in both gate forms (inverted inputs vs. inverted output) for both laws.
// The results are registered, and failing vectors are counted. The lowest
// failing vector is recorded. The inject input flips the right-hand sides so
// that a bench can confirm that mismatches are caught.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   start       begin a sweep (honoured in IDLE or DONE only)
//   pause       freeze the sweep in place while high
//   inject[1:0] bit0 flips law1_rhs, bit1 flips law2_rhs at the evaluating edge
//   vec         vector that the current result belongs to
//   law1_lhs    &(~vec)
//   law1_rhs    ~(|vec) ^ inject[0]
//   law2_lhs    |(~vec)
//   law2_rhs    ~(&vec) ^ inject[1]
//   valid       result outputs carry a fresh evaluation this cycle
//   busy        sweep in progress
//   done        sweep finished, results held
//   fail_cnt    failing vectors in the current or last sweep
//   fail_seen   at least one failure in this sweep
//   first_fail  lowest-numbered failing vector (meaningful when fail_seen)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_SWEEP | evaluating one vector per unpaused cycle until cnt reaches 2^WIDTH
// S_DONE  | sweep complete, results and fail state held, start re-arms

module demorgan_sweep #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic [1:0]       inject,
   output logic [WIDTH-1:0] vec,
   output logic             law1_lhs,
   output logic             law1_rhs,
   output logic             law2_lhs,
   output logic             law2_rhs,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   fail_cnt,
   output logic             fail_seen,
   output logic [WIDTH-1:0] first_fail
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // The counter is one bit wider than the vector. Its MSB becomes set only
   // after the all-ones vector has been evaluated, so the vector never wraps.
   logic [WIDTH:0]   cnt;
   logic             term;
   logic             go;
   logic             eval;
   logic [WIDTH-1:0] cur_vec;
   logic             e_l1l, e_l1r, e_l2l, e_l2r;
   logic             e_fail;

   assign term    = cnt[WIDTH];
   assign go      = start && (state != S_SWEEP);
   assign eval    = (state == S_SWEEP) && !pause && !term;
   assign cur_vec = cnt[WIDTH-1:0];

   assign e_l1l  = &(~cur_vec);
   assign e_l1r  = ~(|cur_vec) ^ inject[0];
   assign e_l2l  = |(~cur_vec);
   assign e_l2r  = ~(&cur_vec) ^ inject[1];
   assign e_fail = (e_l1l != e_l1r) || (e_l2l != e_l2r);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // The terminal cycle also respects pause, so each paused cycle shifts
   // entry into DONE by one edge.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SWEEP;
         S_SWEEP: if (!pause && term) state_nxt = S_DONE;
         S_DONE:  if (start) state_nxt = S_SWEEP;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         vec        <= '0;
         law1_lhs   <= 1'b0;
         law1_rhs   <= 1'b0;
         law2_lhs   <= 1'b0;
         law2_rhs   <= 1'b0;
         valid      <= 1'b0;
         fail_cnt   <= '0;
         fail_seen  <= 1'b0;
         first_fail <= '0;
      end else if (go) begin
         // The previous results stay visible until the first new result.
         cnt        <= '0;
         valid      <= 1'b0;
         fail_cnt   <= '0;
         fail_seen  <= 1'b0;
         first_fail <= '0;
      end else if (eval) begin
         cnt      <= cnt + 1'b1;
         vec      <= cur_vec;
         law1_lhs <= e_l1l;
         law1_rhs <= e_l1r;
         law2_lhs <= e_l2l;
         law2_rhs <= e_l2r;
         valid    <= 1'b1;
         if (e_fail) begin
            fail_cnt <= fail_cnt + 1'b1;
            if (!fail_seen) begin
               fail_seen  <= 1'b1;
               first_fail <= cur_vec;
            end
         end
      end else begin
         valid <= 1'b0;
      end
   end

   assign busy = (state == S_SWEEP);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_demorgan_sweep.sv
// Bench for demorgan_sweep. It instantiates WIDTH=2 and WIDTH=4 instances and
// runs directed sweeps against a scoreboard of expected results.
module tb_demorgan_sweep;

   logic clk = 1'b0;
   logic reset;
   logic start2, start4, pause;
   logic [1:0] inject;

   logic [1:0] vec2, ff2;
   logic [2:0] fc2;
   logic a2, b2, c2, d2, v2, bz2, dn2, fs2;

   logic [3:0] vec4, ff4;
   logic [4:0] fc4;
   logic a4, b4, c4, d4, v4, bz4, dn4, fs4;

   always #5 clk = ~clk;

   demorgan_sweep #(.WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .pause(pause), .inject(inject),
      .vec(vec2), .law1_lhs(a2), .law1_rhs(b2), .law2_lhs(c2), .law2_rhs(d2),
      .valid(v2), .busy(bz2), .done(dn2), .fail_cnt(fc2), .fail_seen(fs2),
      .first_fail(ff2));

   demorgan_sweep #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .pause(pause), .inject(inject),
      .vec(vec4), .law1_lhs(a4), .law1_rhs(b4), .law2_lhs(c4), .law2_rhs(d4),
      .valid(v4), .busy(bz4), .done(dn4), .fail_cnt(fc4), .fail_seen(fs4),
      .first_fail(ff4));

   bit sel4 = 1'b0;
   logic [7:0] o_vec, o_ff;
   logic [8:0] o_fc;
   logic o_l1l, o_l1r, o_l2l, o_l2r, o_valid, o_busy, o_done, o_fs;

   always_comb begin
      o_vec   = sel4 ? 8'(vec4) : 8'(vec2);
      o_ff    = sel4 ? 8'(ff4)  : 8'(ff2);
      o_fc    = sel4 ? 9'(fc4)  : 9'(fc2);
      o_l1l   = sel4 ? a4  : a2;
      o_l1r   = sel4 ? b4  : b2;
      o_l2l   = sel4 ? c4  : c2;
      o_l2r   = sel4 ? d4  : d2;
      o_valid = sel4 ? v4  : v2;
      o_busy  = sel4 ? bz4 : bz2;
      o_done  = sel4 ? dn4 : dn2;
      o_fs    = sel4 ? fs4 : fs2;
   end

   typedef struct {
      int   v;
      logic l1l, l1r, l2l, l2r;
      int   fcnt;
      logic fseen;
      int   ffirst;
   } exp_t;

   exp_t sb[$];
   logic [1:0] inj_tab [16];
   int n_tests = 0;
   int n_fail  = 0;
   int exp_final_fcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_inj();
      for (int i = 0; i < 16; i++) inj_tab[i] = 2'b00;
   endtask

   // Builds the expected result stream from the law definitions and inj_tab.
   task automatic push_all(input int w);
      exp_t e;
      int all1, fcnt, ffirst;
      logic fseen;
      all1 = (1 << w) - 1;
      fcnt = 0; fseen = 1'b0; ffirst = 0;
      for (int v = 0; v <= all1; v++) begin
         e.v   = v;
         e.l1l = (v == 0);
         e.l1r = (v == 0) ^ inj_tab[v][0];
         e.l2l = (v != all1);
         e.l2r = (v != all1) ^ inj_tab[v][1];
         if ((e.l1l != e.l1r) || (e.l2l != e.l2r)) begin
            fcnt++;
            if (!fseen) begin fseen = 1'b1; ffirst = v; end
         end
         e.fcnt = fcnt; e.fseen = fseen; e.ffirst = ffirst;
         sb.push_back(e);
      end
      exp_final_fcnt = fcnt;
   endtask

   task automatic run(input int w, input int pause_after, input int pause_len,
                      input int exp_done, input int stop_at);
      exp_t e;
      int edges, next_k, prem, held;
      bit finished, was_paused;
      sel4 = (w == 4);
      push_all(w);
      if (sel4) start4 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0; start4 = 1'b0;
      chk("busy_after_start", o_busy, 1);
      chk("valid_after_start", o_valid, 0);
      edges = 0; next_k = 0; prem = 0; held = 0; finished = 1'b0;
      while (!finished && edges < 64) begin
         pause  = (prem > 0);
         inject = (next_k < (1 << w)) ? inj_tab[next_k] : 2'b00;
         was_paused = pause;
         @(posedge clk); #1;
         edges++;
         if (was_paused) begin
            prem--;
            chk("valid_in_pause", o_valid, 0);
            chk("vec_in_pause", o_vec, held);
         end else if (o_valid) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               chk("vec", o_vec, e.v);
               chk("law1_lhs", o_l1l, e.l1l);
               chk("law1_rhs", o_l1r, e.l1r);
               chk("law2_lhs", o_l2l, e.l2l);
               chk("law2_rhs", o_l2r, e.l2r);
               chk("fail_cnt", o_fc, e.fcnt);
               chk("fail_seen", o_fs, e.fseen);
               chk("first_fail", o_ff, e.ffirst);
               next_k++;
               held = e.v;
               if (e.v == pause_after) prem = pause_len;
               if (e.v == stop_at) begin
                  pause = 1'b0; inject = 2'b00;
                  return;
               end
            end
         end
         if (o_done) finished = 1'b1;
      end
      pause = 1'b0; inject = 2'b00;
      chk("done_edges", edges, exp_done);
      chk("done_flag", o_done, 1);
      chk("busy_at_done", o_busy, 0);
      chk("valid_at_done", o_valid, 0);
      chk("sb_drained", sb.size(), 0);
      chk("final_fail_cnt", o_fc, exp_final_fcnt);
      @(posedge clk); #1;
      chk("done_hold", o_done, 1);
      chk("vec_hold", o_vec, (1 << w) - 1);
      chk("fail_cnt_hold", o_fc, exp_final_fcnt);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_vec"}, o_vec, 0);
      chk({tag, "_laws"}, {o_l1l, o_l1r, o_l2l, o_l2r}, 0);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_fail_cnt"}, o_fc, 0);
      chk({tag, "_fail_seen"}, o_fs, 0);
      chk({tag, "_first_fail"}, o_ff, 0);
   endtask

   initial begin
      reset = 1'b1; start2 = 1'b0; start4 = 1'b0; pause = 1'b0; inject = 2'b00;
      clear_inj();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      sel4 = 1'b0; #1 chk_reset_vals("rst2");
      sel4 = 1'b1; #1 chk_reset_vals("rst4");
      @(posedge clk); #1;

      // Clean WIDTH=2 sweep
      clear_inj();
      run(2, -1, 0, 5, -1);
      chk("clean_fail_seen", o_fs, 0);

      // inject[0] held for every vector
      for (int i = 0; i < 4; i++) inj_tab[i] = 2'b01;
      run(2, -1, 0, 5, -1);
      chk("inj01_fail_cnt", o_fc, 4);
      chk("inj01_first_fail", o_ff, 0);
      chk("inj01_fail_seen", o_fs, 1);

      // inject[1] only at the edge that evaluates vec=2
      clear_inj();
      inj_tab[2] = 2'b10;
      run(2, -1, 0, 5, -1);
      chk("inj10_fail_cnt", o_fc, 1);
      chk("inj10_first_fail", o_ff, 2);

      // Three pause cycles after vec=1 is shown
      clear_inj();
      run(2, 1, 3, 8, -1);

      // Asynchronous reset while vec=2 is shown with one failure recorded
      clear_inj();
      inj_tab[1] = 2'b10;
      run(2, -1, 0, 5, 2);
      chk("pre_reset_fail_cnt", o_fc, 1);
      chk("pre_reset_busy", o_busy, 1);
      #2 reset = 1'b1;
      #1 chk_reset_vals("async_rst");
      sb.delete();
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("idle_no_start", o_busy, 0);
      clear_inj();
      run(2, -1, 0, 5, -1);
      chk("post_reset_fail_cnt", o_fc, 0);

      // WIDTH=4 clean sweep
      clear_inj();
      run(4, -1, 0, 17, -1);
      chk("w4_fail_seen", o_fs, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
